// File: rtl/aibcr3_io_seq_pkg.sv
// rtl/aibcr3_io_seq_pkg.sv - shared types and constants for the aibcr3 IO pad sequencer
package aibcr3_io_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PULL    = 3'd1,
    ST_RAMP_UP = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RAMP_DN = 3'd4
  } seq_state_e;

  localparam logic [1:0] PULL_NONE = 2'b00;
  localparam logic [1:0] PULL_DN   = 2'b01;
  localparam logic [1:0] PULL_UP   = 2'b10;

  localparam logic [1:0] DRV_MAX = 2'b11;

endpackage

// File: rtl/aibcr3_io_seq_ramp.sv
// rtl/aibcr3_io_seq_ramp.sv - 2-bit saturating drive-code stepper for one PMOS/NMOS leg
module aibcr3_io_seq_ramp
  import aibcr3_io_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_step_up,
  input  logic       i_step_dn,
  input  logic [1:0] i_target,
  output logic [1:0] o_code,
  output logic       o_at_target,
  output logic       o_at_zero
);

  logic [1:0] r_code;

  // Up-steps stop at the target (and never wrap past DRV_MAX); down-steps stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_code <= 2'b00;
    end else if (i_step_up && (r_code < i_target) && (r_code != DRV_MAX)) begin
      r_code <= r_code + 2'd1;
    end else if (i_step_dn && (r_code != 2'b00)) begin
      r_code <= r_code - 2'd1;
    end
  end

  assign o_code      = r_code;
  assign o_at_target = (r_code == i_target);
  assign o_at_zero   = (r_code == 2'b00);

endmodule

// File: rtl/aibcr3_io_seq.sv
// rtl/aibcr3_io_seq.sv - per-pad enable/disable sequencer for the aibcr3 analog IO cell
// Optional por_vcchssi 2-flop synchronizer: define AIBCR3_IO_SEQ_PORSYNC_EN.
module aibcr3_io_seq
  import aibcr3_io_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int STEP_CYC   = 4,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_por_vcchssi,
  input  logic       i_en_req,
  input  logic       i_cfg_tx,
  input  logic       i_cfg_clk,
  input  logic [1:0] i_cfg_pull,
  input  logic [1:0] i_cfg_pdrv,
  input  logic [1:0] i_cfg_ndrv,
  output logic       o_itx_en_buf,
  output logic [1:0] o_ipdrv_buf,
  output logic [1:0] o_indrv_buf,
  output logic       o_weak_pullupenb,
  output logic       o_weak_pulldownen,
  output logic       o_data_en,
  output logic       o_clk_en,
  output logic       o_en_ack,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic w_por_sync;

`ifdef AIBCR3_IO_SEQ_PORSYNC_EN
  logic r_por_meta;
  logic r_por_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_por_meta <= 1'b1;
      r_por_sync <= 1'b1;
    end else begin
      r_por_meta <= i_por_vcchssi;
      r_por_sync <= r_por_meta;
    end
  end

  assign w_por_sync = r_por_sync;
`else
  assign w_por_sync = i_por_vcchssi;
`endif

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             w_ld_shadow;
  logic             w_clr;
  logic             w_step_up;
  logic             w_step_dn;

  logic       r_sh_tx;
  logic       r_sh_clk;
  logic [1:0] r_sh_pull;
  logic [1:0] r_sh_pdrv;
  logic [1:0] r_sh_ndrv;
  logic       w_sh_tx_nxt;
  logic       w_sh_clk_nxt;
  logic [1:0] w_sh_pull_nxt;

  logic w_p_at_tgt;
  logic w_n_at_tgt;
  logic w_p_at_zero;
  logic w_n_at_zero;

  logic r_itx_en;
  logic r_pu_enb;
  logic r_pd_en;
  logic r_data_en;
  logic r_clk_en;
  logic r_ack;
  logic r_busy;

  logic w_pull_on;
  logic w_itx_nxt;
  logic w_pu_enb_nxt;
  logic w_pd_en_nxt;
  logic w_data_en_nxt;
  logic w_clk_en_nxt;
  logic w_ack_nxt;
  logic w_busy_nxt;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : (r_cnt - CNT_ONE);
    w_ld_shadow = 1'b0;
    w_clr       = 1'b0;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    if (w_por_sync) begin
      // POR drops the pad straight to OFF with no ramp down.
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (i_en_req) begin
            w_state_nxt = ST_PULL;
            w_cnt_nxt   = SETTLE_LD;
            w_ld_shadow = 1'b1;
          end
        end
        ST_PULL: begin
          if (!i_en_req) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end else if (w_cnt_zero) begin
            w_state_nxt = r_sh_tx ? ST_RAMP_UP : ST_ACTIVE;
            w_cnt_nxt   = r_sh_tx ? STEP_LD : '0;
          end
        end
        ST_RAMP_UP: begin
          if (!i_en_req) begin
            w_state_nxt = ST_RAMP_DN;
            w_cnt_nxt   = STEP_LD;
          end else if (w_cnt_zero) begin
            if (w_p_at_tgt && w_n_at_tgt) begin
              w_state_nxt = ST_ACTIVE;
            end else begin
              w_step_up = 1'b1;
              w_cnt_nxt = STEP_LD;
            end
          end
        end
        ST_ACTIVE: begin
          if (!i_en_req) begin
            w_state_nxt = ST_RAMP_DN;
            w_cnt_nxt   = STEP_LD;
          end
        end
        ST_RAMP_DN: begin
          if (w_cnt_zero) begin
            if (w_p_at_zero && w_n_at_zero) begin
              w_state_nxt = ST_OFF;
            end else begin
              w_step_dn = 1'b1;
              w_cnt_nxt = STEP_LD;
            end
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  assign w_sh_tx_nxt   = w_ld_shadow ? i_cfg_tx   : r_sh_tx;
  assign w_sh_clk_nxt  = w_ld_shadow ? i_cfg_clk  : r_sh_clk;
  assign w_sh_pull_nxt = w_ld_shadow ? i_cfg_pull : r_sh_pull;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_tx   <= 1'b0;
      r_sh_clk  <= 1'b0;
      r_sh_pull <= PULL_NONE;
      r_sh_pdrv <= 2'b00;
      r_sh_ndrv <= 2'b00;
    end else if (w_ld_shadow) begin
      r_sh_tx   <= i_cfg_tx;
      r_sh_clk  <= i_cfg_clk;
      r_sh_pull <= i_cfg_pull;
      r_sh_pdrv <= i_cfg_pdrv;
      r_sh_ndrv <= i_cfg_ndrv;
    end
  end

  aibcr3_io_seq_ramp u_ramp_p (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_step_up   (w_step_up),
    .i_step_dn   (w_step_dn),
    .i_target    (r_sh_pdrv),
    .o_code      (o_ipdrv_buf),
    .o_at_target (w_p_at_tgt),
    .o_at_zero   (w_p_at_zero)
  );

  aibcr3_io_seq_ramp u_ramp_n (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_step_up   (w_step_up),
    .i_step_dn   (w_step_dn),
    .i_target    (r_sh_ndrv),
    .o_code      (o_indrv_buf),
    .o_at_target (w_n_at_tgt),
    .o_at_zero   (w_n_at_zero)
  );

  // Outputs decode the next state so they line up with the registered drive codes.
  always_comb begin
    w_pull_on     = (w_state_nxt == ST_PULL) || (w_state_nxt == ST_RAMP_UP) ||
                    (!w_sh_tx_nxt && ((w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_RAMP_DN)));
    w_itx_nxt     = w_sh_tx_nxt && ((w_state_nxt == ST_RAMP_UP) || (w_state_nxt == ST_ACTIVE) ||
                                    (w_state_nxt == ST_RAMP_DN));
    w_pu_enb_nxt  = !(w_pull_on && (w_sh_pull_nxt == PULL_UP));
    w_pd_en_nxt   = w_pull_on && (w_sh_pull_nxt == PULL_DN);
    w_ack_nxt     = (w_state_nxt == ST_ACTIVE);
    w_data_en_nxt = w_ack_nxt && !w_sh_clk_nxt;
    w_clk_en_nxt  = w_ack_nxt && w_sh_clk_nxt;
    w_busy_nxt    = (w_state_nxt == ST_PULL) || (w_state_nxt == ST_RAMP_UP) ||
                    (w_state_nxt == ST_RAMP_DN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_itx_en  <= 1'b0;
      r_pu_enb  <= 1'b1;
      r_pd_en   <= 1'b0;
      r_data_en <= 1'b0;
      r_clk_en  <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_itx_en  <= w_itx_nxt;
      r_pu_enb  <= w_pu_enb_nxt;
      r_pd_en   <= w_pd_en_nxt;
      r_data_en <= w_data_en_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_itx_en_buf      = r_itx_en;
  assign o_weak_pullupenb  = r_pu_enb;
  assign o_weak_pulldownen = r_pd_en;
  assign o_data_en         = r_data_en;
  assign o_clk_en          = r_clk_en;
  assign o_en_ack          = r_ack;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_aibcr3_io_seq.sv
// tb/tb_aibcr3_io_seq.sv - self-checking bench for aibcr3_io_seq (directed table, corner sequences, random vs model)
module tb_aibcr3_io_seq;

  localparam int SETTLE = 16;
  localparam int STEP   = 4;

  logic       clk = 1'b0;
  logic       rst, por, en, tx, cclk;
  logic [1:0] pull, pdrv, ndrv;

  logic       o_itx, o_pub, o_pd, o_data, o_ck, o_ack, o_busy;
  logic [1:0] o_p, o_n;
  logic [10:0] dut_out;

  always #5 clk = ~clk;

  aibcr3_io_seq #(.SETTLE_CYC(SETTLE), .STEP_CYC(STEP), .CNT_W(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_por_vcchssi     (por),
    .i_en_req          (en),
    .i_cfg_tx          (tx),
    .i_cfg_clk         (cclk),
    .i_cfg_pull        (pull),
    .i_cfg_pdrv        (pdrv),
    .i_cfg_ndrv        (ndrv),
    .o_itx_en_buf      (o_itx),
    .o_ipdrv_buf       (o_p),
    .o_indrv_buf       (o_n),
    .o_weak_pullupenb  (o_pub),
    .o_weak_pulldownen (o_pd),
    .o_data_en         (o_data),
    .o_clk_en          (o_ck),
    .o_en_ack          (o_ack),
    .o_busy            (o_busy)
  );

  // {itx, pdrv, ndrv, pullupenb, pulldownen, data_en, clk_en, en_ack, busy}
  assign dut_out = {o_itx, o_p, o_n, o_pub, o_pd, o_data, o_ck, o_ack, o_busy};

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", nm, $time, act, exp);
    end
  endtask

  // Reference model: pad phase plus elapsed-cycle dwell timer.
  localparam int P_OFF = 0, P_PULL = 1, P_UP = 2, P_ON = 3, P_DN = 4;
  int       m_ph, m_t, m_p, m_n, m_tp, m_tn;
  bit       m_tx, m_ck, m_pd1, m_pd2;
  bit [1:0] m_pull;

  function automatic logic [10:0] model_out();
    bit pull_on, itx, pub, pdn, ack, busy;
    logic [1:0] p2, n2;
    pull_on = (m_ph == P_PULL) || (m_ph == P_UP) || (!m_tx && (m_ph == P_ON || m_ph == P_DN));
    itx     = m_tx && (m_ph == P_UP || m_ph == P_ON || m_ph == P_DN);
    pub     = !(pull_on && m_pull == 2'b10);
    pdn     = pull_on && m_pull == 2'b01;
    ack     = (m_ph == P_ON);
    busy    = (m_ph == P_PULL) || (m_ph == P_UP) || (m_ph == P_DN);
    p2 = m_p[1:0];
    n2 = m_n[1:0];
    return {itx, p2, n2, pub, pdn, ack && !m_ck, ack && m_ck, ack, busy};
  endfunction

  task automatic model_step();
    bit ps;
    if (rst) begin
      m_ph = P_OFF; m_t = 0; m_p = 0; m_n = 0; m_tp = 0; m_tn = 0;
      m_tx = 0; m_ck = 0; m_pull = 0; m_pd1 = 1; m_pd2 = 1;
      return;
    end
`ifdef AIBCR3_IO_SEQ_PORSYNC_EN
    ps = m_pd2;
    m_pd2 = m_pd1;
    m_pd1 = por;
`else
    ps = por;
`endif
    if (ps) begin
      m_ph = P_OFF; m_t = 0; m_p = 0; m_n = 0;
      return;
    end
    case (m_ph)
      P_OFF: if (en) begin
        m_ph = P_PULL; m_t = 0;
        m_tx = tx; m_ck = cclk; m_pull = pull; m_tp = int'(pdrv); m_tn = int'(ndrv);
      end
      P_PULL: if (!en) m_ph = P_OFF;
        else begin
          m_t++;
          if (m_t == SETTLE) begin
            m_t = 0;
            m_ph = m_tx ? P_UP : P_ON;
          end
        end
      P_UP: if (!en) begin m_ph = P_DN; m_t = 0; end
        else begin
          m_t++;
          if (m_t == STEP) begin
            m_t = 0;
            if (m_p == m_tp && m_n == m_tn) m_ph = P_ON;
            else begin
              if (m_p < m_tp) m_p++;
              if (m_n < m_tn) m_n++;
            end
          end
        end
      P_ON: if (!en) begin m_ph = P_DN; m_t = 0; end
      default: begin
        m_t++;
        if (m_t == STEP) begin
          m_t = 0;
          if (m_p == 0 && m_n == 0) m_ph = P_OFF;
          else begin
            if (m_p > 0) m_p--;
            if (m_n > 0) m_n--;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out, model_out());
  endtask

  typedef struct {
    string      nm;
    bit         rst, por, en, tx, ck;
    bit [1:0]   pull, pdrv, ndrv;
    int         cyc;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input bit r, input bit e, input bit t, input bit c,
                     input bit [1:0] pl, input bit [1:0] pd, input bit [1:0] nd,
                     input int cy, input logic [10:0] ex);
    vec_t v;
    v.nm = nm; v.rst = r; v.por = 1'b0; v.en = e; v.tx = t; v.ck = c;
    v.pull = pl; v.pdrv = pd; v.ndrv = nd; v.cyc = cy; v.exp = ex;
    tbl.push_back(v);
  endtask

  task automatic set_in(input bit e, input bit t, input bit c,
                        input bit [1:0] pl, input bit [1:0] pd, input bit [1:0] nd);
    en = e; tx = t; cclk = c; pull = pl; pdrv = pd; ndrv = nd;
  endtask

  initial begin
    rst = 1'b1; por = 1'b0; en = 1'b0; tx = 1'b0; cclk = 1'b0;
    pull = 2'b00; pdrv = 2'b00; ndrv = 2'b00;

    // TX bring-up pdrv=11 ndrv=10, hold, cfg change ignored, ramp down
    add("reset",        1, 0, 1, 0, 2'b00, 2'b11, 2'b10,  5, 11'b0_00_00_1_0_0_0_0_0);
    add("idle",         0, 0, 1, 0, 2'b00, 2'b11, 2'b10,  3, 11'b0_00_00_1_0_0_0_0_0);
    add("pull_entry",   0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  1, 11'b0_00_00_1_0_0_0_0_1);
    add("ramp_start",   0, 1, 1, 0, 2'b00, 2'b11, 2'b10, 16, 11'b1_00_00_1_0_0_0_0_1);
    add("code01",       0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  4, 11'b1_01_01_1_0_0_0_0_1);
    add("code10",       0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  4, 11'b1_10_10_1_0_0_0_0_1);
    add("code11",       0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  4, 11'b1_11_10_1_0_0_0_0_1);
    add("pre_ack",      0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  3, 11'b1_11_10_1_0_0_0_0_1);
    add("ack_at_33",    0, 1, 1, 0, 2'b00, 2'b11, 2'b10,  1, 11'b1_11_10_1_0_1_0_1_0);
    add("cfg_ignored",  0, 1, 1, 0, 2'b00, 2'b01, 2'b00,  5, 11'b1_11_10_1_0_1_0_1_0);
    add("dn_start",     0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  1, 11'b1_11_10_1_0_0_0_0_1);
    add("dn_10",        0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b1_10_01_1_0_0_0_0_1);
    add("dn_01",        0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b1_01_00_1_0_0_0_0_1);
    add("dn_00",        0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b1_00_00_1_0_0_0_0_1);
    add("tx_off",       0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b0_00_00_1_0_0_0_0_0);
    // re-entry picks up the new drive target
    add("re_pull",      0, 1, 1, 0, 2'b00, 2'b01, 2'b00,  1, 11'b0_00_00_1_0_0_0_0_1);
    add("re_ramp",      0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 16, 11'b1_00_00_1_0_0_0_0_1);
    add("new_cfg",      0, 1, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b1_01_00_1_0_0_0_0_1);
    add("new_active",   0, 1, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b1_01_00_1_0_1_0_1_0);
    add("new_dn",       0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  5, 11'b1_00_00_1_0_0_0_0_1);
    add("new_off",      0, 0, 1, 0, 2'b00, 2'b01, 2'b00,  4, 11'b0_00_00_1_0_0_0_0_0);
    // RX clock pad with pullup
    add("rx_pull",      0, 1, 0, 1, 2'b10, 2'b00, 2'b00,  1, 11'b0_00_00_0_0_0_0_0_1);
    add("rx_active",    0, 1, 0, 1, 2'b10, 2'b00, 2'b00, 16, 11'b0_00_00_0_0_0_1_1_0);
    add("rx_dn",        0, 0, 0, 1, 2'b10, 2'b00, 2'b00,  4, 11'b0_00_00_0_0_0_0_0_1);
    add("rx_off",       0, 0, 0, 1, 2'b10, 2'b00, 2'b00,  1, 11'b0_00_00_1_0_0_0_0_0);
    // abort inside PULL, pulldown visible, no TX enable
    add("abort_pull",   0, 1, 1, 0, 2'b01, 2'b11, 2'b11,  5, 11'b0_00_00_1_1_0_0_0_1);
    add("abort_off",    0, 0, 1, 0, 2'b01, 2'b11, 2'b11,  1, 11'b0_00_00_1_0_0_0_0_0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; por = tbl[i].por;
      set_in(tbl[i].en, tbl[i].tx, tbl[i].ck, tbl[i].pull, tbl[i].pdrv, tbl[i].ndrv);
      repeat (tbl[i].cyc) tick();
      check(tbl[i].nm, dut_out, tbl[i].exp);
    end

    // por asserted in RAMP_UP at code 01: immediate drop, no ramp down, overrides en_req
    set_in(1, 1, 0, 2'b10, 2'b11, 2'b11);
    repeat (1 + SETTLE + STEP) tick();
    check("por_pre", dut_out, 11'b1_01_01_0_0_0_0_0_1);
    por = 1'b1;
    tick();
`ifdef AIBCR3_IO_SEQ_PORSYNC_EN
    tick(); tick();
`endif
    check("por_drop", dut_out, 11'b0_00_00_1_0_0_0_0_0);
    repeat (3) tick();
    check("por_hold", dut_out, 11'b0_00_00_1_0_0_0_0_0);
    por = 1'b0; en = 1'b0;
    repeat (3) tick();

    // en_req dropped in RAMP_UP: ramps down from current code
    set_in(1, 1, 0, 2'b00, 2'b11, 2'b11);
    repeat (1 + SETTLE + STEP) tick();
    en = 1'b0;
    tick();
    check("up_abort", dut_out, 11'b1_01_01_1_0_0_0_0_1);
    repeat (STEP) tick();
    check("up_abort_00", dut_out, 11'b1_00_00_1_0_0_0_0_1);
    en = 1'b1;
    repeat (STEP) tick();
    check("dn_ignores_en", dut_out, 11'b0_00_00_1_0_0_0_0_0);
    tick();
    check("resequence", dut_out, 11'b0_00_00_1_0_0_0_0_1);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (por) por = ($urandom_range(0, 2) != 0);
      else     por = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        tx = 1'($urandom); cclk = 1'($urandom);
        pull = 2'($urandom); pdrv = 2'($urandom); ndrv = 2'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
